dram_responder: RTL

Data-memory responder for the single-cycle RV32 core: it serves the core's data port (write enable, word address, write data) and returns read data in the same cycle. It is a word-addressed RAM plus a small MMIO page holding an LED register, synchronized switch inputs, a free-running cycle counter and a compare timer with a sticky interrupt flag. It sits beside the instruction ROM at top level, directly on the core's data port.

---
 rtl/dram_responder_if.sv | 12 +
 rtl/dram_responder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dram_responder_if.sv
// Data-port bundle between the single-cycle core and its data memory.
// The core drives the strobe, address and store data; the memory returns
// read data combinationally in the same cycle.
interface dram_responder_if;
    logic        dram_we;
    logic [31:0] addra;
    logic [31:0] data_wr;
    logic [31:0] rd_data;

    modport master (output dram_we, output addra, output data_wr, input rd_data);
    modport slave  (input dram_we, input addra, input data_wr, output rd_data);
endinterface

// File: rtl/dram_responder.sv
// Data-memory responder: word-addressed RAM plus an MMIO page holding an
// LED register, synchronized switches, a free-running counter and a
// compare timer with a sticky interrupt flag. Reads are combinational,
// writes land on the rising edge.
module dram_responder #(
    parameter int          RAM_WORDS = 4096,
    parameter int          LED_W     = 24,
    parameter int          SW_W      = 24,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_F000
) (
    input  logic             clk,
    input  logic             rst_n,
    dram_responder_if.slave  bus,
    input  logic [SW_W-1:0]  sw_i,
    output logic [LED_W-1:0] led_o,
    output logic             timer_irq
);

    localparam int RAM_AW = $clog2(RAM_WORDS);

    // Word offsets inside the MMIO page (byte offset >> 2).
    localparam logic [9:0] OFF_LED    = 10'h000;
    localparam logic [9:0] OFF_SW     = 10'h001;
    localparam logic [9:0] OFF_CNT    = 10'h002;
    localparam logic [9:0] OFF_CMP    = 10'h003;
    localparam logic [9:0] OFF_STATUS = 10'h004;

    logic [31:0]       r_mem [RAM_WORDS];
    logic [LED_W-1:0]  r_led;
    logic [SW_W-1:0]   r_sw_meta;
    logic [SW_W-1:0]   r_sw_sync;
    logic [31:0]       r_cnt;
    logic [31:0]       r_cmp;
    logic              r_irq;

    logic              w_is_ram;
    logic              w_is_mmio;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [9:0]        w_off;
    logic              w_wr_mmio;
    logic              w_wr_led;
    logic              w_wr_cnt;
    logic              w_wr_cmp;
    logic              w_clr_irq;
    logic              w_match;
    logic [31:0]       w_rd;
    logic              w_unused_lsb;

    // Byte-address bits [1:0] carry no meaning on a word-wide port.
    assign w_unused_lsb = ^bus.addra[1:0];

    // Address decode: RAM at the bottom, MMIO page at MMIO_BASE, rest unmapped.
    assign w_is_ram  = (bus.addra[31:RAM_AW+2] == '0);
    assign w_ram_idx = bus.addra[RAM_AW+1:2];
    assign w_is_mmio = (bus.addra[31:12] == MMIO_BASE[31:12]);
    assign w_off     = bus.addra[11:2];

    assign w_wr_mmio = bus.dram_we && w_is_mmio;
    assign w_wr_led  = w_wr_mmio && (w_off == OFF_LED);
    assign w_wr_cnt  = w_wr_mmio && (w_off == OFF_CNT);
    assign w_wr_cmp  = w_wr_mmio && (w_off == OFF_CMP);
    assign w_clr_irq = w_wr_mmio && (w_off == OFF_STATUS) && bus.data_wr[0];

    // Match uses the registered count, so a CNT load equal to CMP only
    // matches once it has landed.
    assign w_match = (r_cmp != '0) && (r_cnt == r_cmp);

    // RAM write port.
    // NOTE: RAM has no reset; clearing thousands of words would need a reset
    // fan-out into the array and blocks mapping it onto block RAM.
    always_ff @(posedge clk) begin
        if (bus.dram_we && w_is_ram) begin
            r_mem[w_ram_idx] <= bus.data_wr;
        end
    end

    // MMIO registers: LED, counter with load priority, compare value.
    // NOTE: non-blocking assignments make every register sample pre-edge
    // values, so r_cnt feeding w_match sees the old count regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
            r_cnt <= '0;
            r_cmp <= '0;
        end else begin
            if (w_wr_led) begin
                r_led <= bus.data_wr[LED_W-1:0];
            end
            if (w_wr_cnt) begin
                r_cnt <= bus.data_wr;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_wr_cmp) begin
                r_cmp <= bus.data_wr;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw_i;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Sticky timer flag: a match sets it, W1C clears it, set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else if (w_match) begin
            r_irq <= 1'b1;
        end else if (w_clr_irq) begin
            r_irq <= 1'b0;
        end
    end

    // Combinational read mux; unmapped space and unused offsets read zero.
    // NOTE: w_rd gets its default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_rd = '0;
        if (w_is_ram) begin
            w_rd = r_mem[w_ram_idx];
        end else if (w_is_mmio) begin
            case (w_off)
                OFF_LED:    w_rd[LED_W-1:0] = r_led;
                OFF_SW:     w_rd[SW_W-1:0]  = r_sw_sync;
                OFF_CNT:    w_rd            = r_cnt;
                OFF_CMP:    w_rd            = r_cmp;
                OFF_STATUS: w_rd[0]         = r_irq;
                default:    w_rd            = '0;
            endcase
        end
    end

    assign bus.rd_data = w_rd;
    assign led_o       = r_led;
    assign timer_irq   = r_irq;

endmodule
